// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared types and constants for the decoder scan sequencer.
package decoder_scan_ctrl_pkg;

    // Select width is tied to the downstream 3-to-8 decoder.
    localparam int unsigned SEL_W     = 3;
    // Number of blanking cycles inserted between consecutive rows.
    localparam int unsigned BLANK_CYC = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRE     = 3'd1,
        ST_DRIVE   = 3'd2,
        ST_BLANK_A = 3'd3,
        ST_BLANK_B = 3'd4
    } state_e;

    // Row that follows `cur`; wraps to row 0 after the last scanned row.
    function automatic logic [SEL_W-1:0] next_row(input logic [SEL_W-1:0] cur,
                                                  input logic [SEL_W-1:0] last);
        return (cur == last) ? '0 : cur + SEL_W'(1);
    endfunction

endpackage

// File: rtl/decoder_scan_ctrl_dwell_timer.sv
// Loadable down-counter timing how long each row stays enabled.
// Saturates at zero; zero_o flags the final active cycle of a row.
module scan_dwell_timer #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] load_val_i,
    output logic               zero_o
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    // Next count: load has priority, otherwise count down to zero and hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer for the 3-to-8 one-hot decoder: walks sel through rows
// 0..last_sel with a programmable dwell and break-before-make blanking.
module decoder_scan_ctrl
    import decoder_scan_ctrl_pkg::*;
#(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [SEL_W-1:0]   last_sel,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_en,
    output logic               row_strobe,
    output logic               busy,
    output logic               done
);

    state_e             state_q, state_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic               mode_q, mode_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               sel_en_q, sel_en_d;
    logic               strobe_q, strobe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               tmr_load;
    logic               tmr_zero;

    scan_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (tmr_load),
        .load_val_i (dwell_q),
        .zero_o     (tmr_zero)
    );

    // Next-state and registered-output decode; sel only moves while sel_en is low.
    always_comb begin
        state_d  = state_q;
        dwell_d  = dwell_q;
        last_d   = last_q;
        mode_d   = mode_q;
        sel_d    = sel_q;
        sel_en_d = sel_en_q;
        strobe_d = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d  = ST_PRE;
                    dwell_d  = dwell;
                    last_d   = last_sel;
                    mode_d   = mode;
                    sel_d    = '0;
                    sel_en_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            ST_PRE: begin
                state_d  = ST_DRIVE;
                sel_en_d = 1'b1;
                strobe_d = 1'b1;
                tmr_load = 1'b1;
            end
            ST_DRIVE: begin
                if (tmr_zero) begin
                    sel_en_d = 1'b0;
                    if ((sel_q != last_q) || mode_q) begin
                        state_d = ST_BLANK_A;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_BLANK_A: begin
                state_d = ST_BLANK_B;
                sel_d   = next_row(sel_q, last_q);
            end
            ST_BLANK_B: begin
                state_d  = ST_DRIVE;
                sel_en_d = 1'b1;
                strobe_d = 1'b1;
                tmr_load = 1'b1;
            end
            default: begin
                state_d  = ST_IDLE;
                sel_en_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase

        // Abort overrides whatever the scan would have done; sel is left as-is.
        if (stop && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            sel_d    = sel_q;
            sel_en_d = 1'b0;
            strobe_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            tmr_load = 1'b0;
        end
    end

    // State, shadow and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            dwell_q  <= '0;
            last_q   <= '0;
            mode_q   <= 1'b0;
            sel_q    <= '0;
            sel_en_q <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            last_q   <= last_d;
            mode_q   <= mode_d;
            sel_q    <= sel_d;
            sel_en_q <= sel_en_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sel        = sel_q;
    assign sel_en     = sel_en_q;
    assign row_strobe = strobe_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl. Edge 1 is the first rising edge that
// sees start; outputs are sampled 1 time unit after each rising edge.
module tb_decoder_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, mode;
    logic [7:0] dwell;
    logic [2:0] last_sel;
    logic [2:0] sel;
    logic       sel_en, row_strobe, busy, done;
    logic [6:0] obs;

    int n_cmp = 0;
    int n_err = 0;

    decoder_scan_ctrl #(
        .DWELL_W (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .dwell      (dwell),
        .last_sel   (last_sel),
        .sel        (sel),
        .sel_en     (sel_en),
        .row_strobe (row_strobe),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Observed outputs packed as {sel, sel_en, row_strobe, busy, done}.
    assign obs = {sel, sel_en, row_strobe, busy, done};

    function automatic logic [6:0] pk(input int s, input bit en, input bit stb,
                                      input bit bsy, input bit dn);
        logic [2:0] s3;
        s3 = 3'(s);
        return {s3, en, stb, bsy, dn};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle protocol checks on the decoder drive.
    logic       prev_valid = 1'b0;
    logic [2:0] prev_sel;
    logic       prev_en;
    always @(posedge clk) begin
        #1;
        if (rst_n !== 1'b1) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid) begin
                n_cmp++;
                if (prev_en && sel_en && (sel !== prev_sel)) begin
                    n_err++;
                    $display("FAIL chk_sel_stable t=%0t sel got %0d required %0d", $time, sel, prev_sel);
                end
                n_cmp++;
                if ((sel !== prev_sel) && (sel_en !== prev_en)) begin
                    n_err++;
                    $display("FAIL chk_glitch t=%0t sel %0d->%0d sel_en %b->%b, required not both", $time, prev_sel, sel, prev_en, sel_en);
                end
                n_cmp++;
                if (row_strobe && !sel_en) begin
                    n_err++;
                    $display("FAIL chk_strobe_en t=%0t row_strobe=1 sel_en got %b required 1", $time, sel_en);
                end
            end
            prev_valid = 1'b1;
            prev_sel   = sel;
            prev_en    = sel_en;
        end
    end

    task automatic test_reset();
        #3;
        n_cmp++;
        if (obs !== 7'b0) begin
            n_err++;
            $display("FAIL reset_async got %b required %b", obs, 7'b0);
        end
        tick();
        tick();
        n_cmp++;
        if (obs !== 7'b0) begin
            n_err++;
            $display("FAIL reset_held got %b required %b", obs, 7'b0);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (obs !== 7'b0) begin
            n_err++;
            $display("FAIL reset_idle got %b required %b", obs, 7'b0);
        end
    endtask

    task automatic test_single_shot();
        int strobes = 0;
        int dones   = 0;
        int p, ph;
        logic [6:0] ex;
        dwell = 8'd2; last_sel = 3'd3; mode = 1'b0; start = 1'b1;
        for (int e = 1; e <= 22; e++) begin
            tick();
            if (e == 1) begin
                // Mid-scan input changes must not affect the running scan.
                start = 1'b0; dwell = 8'd7; last_sel = 3'd1; mode = 1'b1;
            end
            if (e == 1) begin
                ex = pk(0, 0, 0, 1, 0);
            end else if (e <= 19) begin
                p  = (e - 2) / 5;
                ph = (e - 2) % 5;
                ex = pk((ph == 4) ? p + 1 : p, ph < 3, ph == 0, 1, 0);
            end else begin
                ex = pk(3, 0, 0, 0, e == 20);
            end
            if (row_strobe === 1'b1) strobes++;
            if (done === 1'b1) dones++;
            n_cmp++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL single_shot e=%0d got %b required %b", e, obs, ex);
            end
        end
        n_cmp++;
        if (strobes !== 4) begin
            n_err++;
            $display("FAIL single_shot_strobes got %0d required 4", strobes);
        end
        n_cmp++;
        if (dones !== 1) begin
            n_err++;
            $display("FAIL single_shot_done_count got %0d required 1", dones);
        end
    endtask

    task automatic test_continuous();
        int q, ph;
        logic [6:0] ex;
        dwell = 8'd0; last_sel = 3'd7; mode = 1'b1; start = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (e == 1) start = 1'b0;
            if (e == 1) begin
                ex = pk(0, 0, 0, 1, 0);
            end else begin
                q  = (e - 2) / 3;
                ph = (e - 2) % 3;
                ex = pk((ph == 2) ? (q + 1) % 8 : q % 8, ph == 0, ph == 0, 1, 0);
            end
            n_cmp++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL continuous e=%0d got %b required %b", e, obs, ex);
            end
        end
        // Edge 30 is BLANK_A of row 1 (second pass); stop must freeze sel at 1.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_cmp++;
        if (obs !== pk(1, 0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL continuous_stop got %b required %b", obs, pk(1, 0, 0, 0, 0));
        end
    endtask

    task automatic test_abort();
        logic [6:0] exp_rs [1:6];
        dwell = 8'd3; last_sel = 3'd7; mode = 1'b0; start = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            tick();
            if (e == 1) start = 1'b0;
        end
        n_cmp++;
        if (obs !== pk(2, 1, 0, 1, 0)) begin
            n_err++;
            $display("FAIL abort_row2 got %b required %b", obs, pk(2, 1, 0, 1, 0));
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_cmp++;
        if (obs !== pk(2, 0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL abort_stop got %b required %b", obs, pk(2, 0, 0, 0, 0));
        end
        tick();
        n_cmp++;
        if (obs !== pk(2, 0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL abort_idle got %b required %b", obs, pk(2, 0, 0, 0, 0));
        end
        // Restart: two rows, dwell 0, single shot, must begin from row 0.
        exp_rs[1] = pk(0, 0, 0, 1, 0);
        exp_rs[2] = pk(0, 1, 1, 1, 0);
        exp_rs[3] = pk(0, 0, 0, 1, 0);
        exp_rs[4] = pk(1, 0, 0, 1, 0);
        exp_rs[5] = pk(1, 1, 1, 1, 0);
        exp_rs[6] = pk(1, 0, 0, 0, 1);
        dwell = 8'd0; last_sel = 3'd1; mode = 1'b0; start = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 1) start = 1'b0;
            n_cmp++;
            if (obs !== exp_rs[e]) begin
                n_err++;
                $display("FAIL abort_restart e=%0d got %b required %b", e, obs, exp_rs[e]);
            end
        end
    endtask

    task automatic test_edge_inputs();
        logic [6:0] exp_e [1:4];
        exp_e[1] = pk(0, 0, 0, 1, 0);
        exp_e[2] = pk(0, 1, 1, 1, 0);
        exp_e[3] = pk(0, 0, 0, 0, 1);
        exp_e[4] = pk(0, 0, 0, 0, 0);
        dwell = 8'd0; last_sel = 3'd0; mode = 1'b0; start = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            if (e == 1) start = 1'b0;
            n_cmp++;
            if (obs !== exp_e[e]) begin
                n_err++;
                $display("FAIL edge_one_row e=%0d got %b required %b", e, obs, exp_e[e]);
            end
        end
        start = 1'b1; stop = 1'b1;
        for (int e = 1; e <= 2; e++) begin
            tick();
            n_cmp++;
            if (busy !== 1'b0) begin
                n_err++;
                $display("FAIL edge_start_stop e=%0d busy got %b required 0", e, busy);
            end
        end
        start = 1'b0; stop = 1'b0;
        // Continuous with a single row: row 0 repeats with blanking in between.
        mode = 1'b1; start = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            if (e == 1) start = 1'b0;
        end
        n_cmp++;
        if (obs !== pk(0, 1, 1, 1, 0)) begin
            n_err++;
            $display("FAIL edge_cont_row0 got %b required %b", obs, pk(0, 1, 1, 1, 0));
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_cmp++;
        if (obs !== pk(0, 0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL edge_cont_stop got %b required %b", obs, pk(0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_async_reset();
        dwell = 8'd5; last_sel = 3'd7; mode = 1'b1; start = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 1) start = 1'b0;
        end
        n_cmp++;
        if (obs !== pk(1, 1, 1, 1, 0)) begin
            n_err++;
            $display("FAIL areset_pre got %b required %b", obs, pk(1, 1, 1, 1, 0));
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 7'b0) begin
            n_err++;
            $display("FAIL areset_immediate got %b required %b", obs, 7'b0);
        end
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            n_cmp++;
            if (obs !== 7'b0) begin
                n_err++;
                $display("FAIL areset_after e=%0d got %b required %b", e, obs, 7'b0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
        dwell = '0; last_sel = '0;
        test_reset();
        test_single_shot();
        tick();
        test_continuous();
        tick();
        test_abort();
        tick();
        test_edge_inputs();
        tick();
        test_async_reset();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
